// File: rtl/alien_march_ctrl_pkg.sv
// alien_march_ctrl_pkg: shared state/direction types and sprite sizing for the alien march controller
package alien_march_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, MARCH, DESCEND, LANDED} state_t;
    typedef enum logic {RIGHT = 1'b0, LEFT = 1'b1} dir_t;
    localparam int DEFAULT_SCALE = 2;
    localparam int SPRITE_W = 8 * DEFAULT_SCALE;
    function automatic int sprite_w(input int scale);
        return 8 * scale;
    endfunction
endpackage

// File: rtl/alien_march_ctrl_frame_tick_gen.sv
// frame_tick_gen: one-pulse-per-frame tick from the VGA counters, divided down to march step events
module frame_tick_gen
    import alien_march_ctrl_pkg::*;
#(
    parameter int FRAME_V         = 480,
    parameter int FRAMES_PER_STEP = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    input  logic       run,
    input  logic       clear,
    output logic       step
);
    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    logic          cond_q;
    logic          cond_d;
    logic          tick;
    logic [CW-1:0] count;
    // edge of the registered compare, so a counter held at the frame point for many clocks ticks once
    assign tick = cond_q & ~cond_d;
    assign step = run & tick & (count == CW'(FRAMES_PER_STEP - 1));
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cond_q <= 1'b0;
            cond_d <= 1'b0;
            count  <= '0;
        end else begin
            cond_q <= (h_counter == 10'd0) && (v_counter == 10'(FRAME_V));
            cond_d <= cond_q;
            count  <= (clear || !run || step) ? '0 : tick ? count + 1'b1 : count;
        end
    end
endmodule

// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: marches one alien sprite across the screen, dropping and reversing at each edge
module alien_march_ctrl
    import alien_march_ctrl_pkg::*;
#(
    parameter int SCALE           = 2,
    parameter int START_X         = 64,
    parameter int START_Y         = 32,
    parameter int STEP_X          = 4,
    parameter int STEP_Y          = 8,
    parameter int FRAMES_PER_STEP = 30,
    parameter int MIN_X           = 0,
    parameter int MAX_X           = 640,
    parameter int LAND_Y          = 448,
    parameter int FRAME_V         = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    input  logic       start,
    input  logic       hit,
    output logic [9:0] pos_X,
    output logic [9:0] pos_Y,
    output logic       troca,
    output logic       alive,
    output logic       landed
);
    localparam int SW = sprite_w(SCALE);
    state_t      state;
    dir_t        dir;
    logic        run;
    logic        step;
    logic        blocked;
    logic        lands;
    logic [10:0] right_sum;
    logic [10:0] new_y;
    logic [9:0]  next_x;
    assign run = (state == MARCH) || (state == DESCEND);
    frame_tick_gen #(
        .FRAME_V        (FRAME_V),
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .h_counter(h_counter),
        .v_counter(v_counter),
        .run      (run),
        .clear    (start),
        .step     (step)
    );
    // 11-bit sums keep the edge tests free of 10-bit wrap-around
    always_comb begin
        right_sum = {1'b0, pos_X} + 11'(STEP_X + SW);
        blocked   = (dir == RIGHT) ? (right_sum > 11'(MAX_X)) : ({1'b0, pos_X} < 11'(MIN_X + STEP_X));
        next_x    = (dir == RIGHT) ? pos_X + 10'(STEP_X) : pos_X - 10'(STEP_X);
        new_y     = {1'b0, pos_Y} + 11'(STEP_Y);
        lands     = (new_y + 11'(SW)) >= 11'(LAND_Y);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_X  <= 10'(START_X);
            pos_Y  <= 10'(START_Y);
            troca  <= 1'b0;
            alive  <= 1'b0;
            landed <= 1'b0;
            dir    <= RIGHT;
            state  <= IDLE;
        end else if (start) begin
            pos_X  <= 10'(START_X);
            pos_Y  <= 10'(START_Y);
            troca  <= 1'b0;
            alive  <= 1'b1;
            landed <= 1'b0;
            dir    <= RIGHT;
            state  <= MARCH;
        end else if (run && hit) begin
            alive <= 1'b0;
            state <= IDLE;
        end else if (step) begin
            troca <= ~troca;
            if (state == MARCH) begin
                if (blocked) state <= DESCEND;
                else pos_X <= next_x;
            end else begin
                pos_Y  <= new_y[9:0];
                dir    <= (dir == RIGHT) ? LEFT : RIGHT;
                landed <= lands;
                state  <= lands ? LANDED : MARCH;
            end
        end
    end
endmodule

// File: doc/alien_march_ctrl.md
Name: alien_march_ctrl

Overview:
Sequences the position and animation frame of one alien sprite for the sprite renderer in the VGA path. It drives the renderer's pos_X, pos_Y and troca inputs. The alien marches horizontally in fixed steps, drops a row and reverses at each screen edge, and flags a landing that triggers the defeat screen. Timing is derived from the VGA h/v counters: one step per FRAMES_PER_STEP frames.

Parameters:
SCALE, 2, sprite pixel scale; sprite width and height = 8*SCALE
START_X, 64, pos_X loaded on reset/start
START_Y, 32, pos_Y loaded on reset/start
STEP_X, 4, horizontal pixels per step
STEP_Y, 8, vertical pixels per descent
FRAMES_PER_STEP, 30, frame ticks between step events (>=1)
MIN_X, 0, left boundary
MAX_X, 640, right boundary (exclusive)
LAND_Y, 448, landing line; bottom edge reaching it ends the march
FRAME_V, 480, v_counter line that generates the frame tick

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
h_counter  in  10  VGA horizontal counter
v_counter  in  10  VGA vertical counter
start  in  1  1-cycle pulse: reload and begin the march
hit  in  1  1-cycle pulse: alien destroyed
pos_X  out  10  sprite left edge, registered
pos_Y  out  10  sprite top edge, registered
troca  out  1  animation frame select, registered
alive  out  1  sprite active, registered
landed  out  1  alien reached LANDED, registered

Behaviour:
- Reset (reset=0, async):
  - pos_X=START_X, pos_Y=START_Y, troca=0, alive=0, landed=0.
  - dir=RIGHT, frame count=0, state=IDLE.
- Frame tick:
  - cond = (h_counter==0 && v_counter==FRAME_V), registered.
  - tick = rising edge of registered cond, so exactly one clk pulse per frame regardless of the pixel/clk ratio.
- Step event:
  - On tick in MARCH or DESCEND: if count==FRAMES_PER_STEP-1, then step=1 and count clears; else count increments.
  - In IDLE and LANDED, count holds at 0.
- States: IDLE, MARCH, DESCEND, LANDED.
- IDLE: outputs hold. start -> load START_X/START_Y, dir=RIGHT, troca=0, alive=1, landed=0, count=0, go MARCH.
- MARCH on step:
  - troca toggles.
  - dir=RIGHT: if pos_X+STEP_X+8*SCALE > MAX_X, go DESCEND with pos_X unchanged; else pos_X += STEP_X.
  - dir=LEFT: if pos_X < MIN_X+STEP_X, go DESCEND with pos_X unchanged; else pos_X -= STEP_X.
- DESCEND on step:
  - troca toggles, pos_Y += STEP_Y, dir flips.
  - If new pos_Y+8*SCALE >= LAND_Y, go LANDED with landed=1; else go MARCH.
- LANDED: positions and troca frozen, alive stays 1, landed=1. start restarts as in IDLE.
- hit in MARCH/DESCEND: alive=0, go IDLE next cycle, positions and troca frozen. hit in IDLE/LANDED is ignored.
- Priority on the same cycle: start > hit > step.
  - start in any state restarts.
  - hit with step: no move, no troca toggle.
- Outputs change only on clk edges; latency from a step event to the new pos_X/pos_Y/troca is 1 cycle.
- Arithmetic: boundary sums use 11-bit intermediates, so no 10-bit wrap-around. pos_X never leaves [MIN_X, MAX_X-8*SCALE] when START_X is legal.

Decomposition:
- Shared package holds:
  - state enum {IDLE, MARCH, DESCEND, LANDED}
  - dir encoding (RIGHT=0, LEFT=1)
  - SPRITE_W = 8*SCALE
- One sub-module, frame_tick_gen, contains the counter compare, edge detect and per-step divider, and outputs step.
- The FSM and position datapath stay in alien_march_ctrl.

Test Plan:
- reset low mid-march at pos_X=72 -> next sample: pos_X=64, pos_Y=32, troca=0, alive=0, landed=0, IDLE; ticks produce no motion.
- FRAMES_PER_STEP=2, start, 4 frames -> pos_X 64→68→72, troca 0→1→0; pos_X changes exactly 1 cycle after every 2nd tick.
- START_X=600, MAX_X=624, SCALE=2, FRAMES_PER_STEP=1 -> steps give 604, 608, then DESCEND (pos_X=608); next step pos_Y=40, dir=LEFT; next pos_X=604.
- START_Y=424, LAND_Y=448, at right edge -> descent gives pos_Y=432, 432+16>=448 -> LANDED, landed=1; further ticks leave pos_X, pos_Y, troca unchanged; start reloads 64/32 with landed=0.
- hit on the same cycle as a step -> alive=0, pos_X and troca unchanged, IDLE; hit and start together -> restart with alive=1.
- Counters held at h=0, v=480 for 10 clk -> exactly one tick, counted once.
